// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//
// Interrupt request controller placed in front of the single CPU interrupt
// input. It latches rising edges on N_SRC peripheral lines into `pending`. An
// enable mask gates which pending lines may request. The lowest enabled pending
// index wins arbitration. The controller runs the intr/inta handshake and then
// holds the serviced ID until the handler signals end-of-interrupt.
//
// Ports:
//   SI_ClkIn    in  1      system clock, rising edge active
//   SI_Reset_N  in  1      asynchronous active-low reset
//   irq_src     in  N_SRC  raw source levels (rising edge = request)
//   mask_we     in  1      enable-mask write strobe
//   mask_wdata  in  N_SRC  new enable mask (1 = enabled)
//   inta        in  1      CPU acknowledge, honoured only while requesting
//   eoi         in  1      end-of-interrupt pulse, honoured only in service
//   intr        out 1      registered interrupt request to the CPU
//   irq_id      out ID_W   registered ID of the requested/serviced source
//   pending     out N_SRC  latched, not yet acknowledged requests
//   mask        out N_SRC  current enable mask
//   busy        out 1      high while requesting or in service
//
// Build option:
//   IRQ_CTRL_SYNC_EN  when defined, irq_src passes through a 2-flop
//                     synchronizer before edge detection. This adds 2 cycles
//                     of latency. Leave it undefined when the sources are
//                     already synchronous to SI_ClkIn.
// -----------------------------------------------------------------------------
module irq_ctrl #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic             SI_ClkIn,
   input  logic             SI_Reset_N,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             inta,
   input  logic             eoi,
   output logic             intr,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Fixed priority: the lowest set index wins. Bit 0 has the highest priority.
   function automatic logic [ID_W-1:0] lowest_index(input logic [N_SRC-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = ID_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [N_SRC-1:0] src_s;
   logic [N_SRC-1:0] src_q_r;
   logic [N_SRC-1:0] rise_s;
   logic [N_SRC-1:0] eligible_s;
   logic [N_SRC-1:0] clr_s;
   logic             ack_s;
   logic [N_SRC-1:0] pending_r;
   logic [N_SRC-1:0] mask_r;
   logic             intr_r;
   logic             busy_r;
   logic [ID_W-1:0]  irq_id_r;
   state_t           state_r;

`ifdef IRQ_CTRL_SYNC_EN
   logic [N_SRC-1:0] sync1_r;
   logic [N_SRC-1:0] sync2_r;

   // Two-flop synchronizer for asynchronous source lines.
   always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
      if (!SI_Reset_N) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= irq_src;
         sync2_r <= sync1_r;
      end
   end

   assign src_s = sync2_r;
`else
   assign src_s = irq_src;
`endif

   assign rise_s     = src_s & ~src_q_r;
   assign eligible_s = pending_r & mask_r;
   assign ack_s      = (state_r == ST_REQ) && inta;

   // One-hot clear of the pending bit that belongs to the acknowledged ID.
   always_comb begin
      clr_s = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (ack_s && (irq_id_r == ID_W'(i))) begin
            clr_s[i] = 1'b1;
         end else begin
            clr_s[i] = 1'b0;
         end
      end
   end

   // Edge-detect history, pending latch and enable mask.
   // When a set and a clear hit the same pending bit, the set wins because the
   // rise term is ORed in after the clear.
   always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
      if (!SI_Reset_N) begin
         src_q_r   <= '0;
         pending_r <= '0;
         mask_r    <= '0;
      end else begin
         src_q_r   <= src_s;
         pending_r <= (pending_r & ~clr_s) | rise_s;
         if (mask_we) begin
            mask_r <= mask_wdata;
         end else begin
            mask_r <= mask_r;
         end
      end
   end

   // Handshake FSM with registered intr/busy/irq_id.
   // Once REQ is entered, the request is never retracted or re-arbitrated.
   always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
      if (!SI_Reset_N) begin
         state_r  <= ST_IDLE;
         intr_r   <= 1'b0;
         busy_r   <= 1'b0;
         irq_id_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|eligible_s) begin
                  irq_id_r <= lowest_index(eligible_s);
                  intr_r   <= 1'b1;
                  busy_r   <= 1'b1;
                  state_r  <= ST_REQ;
               end else begin
                  intr_r   <= 1'b0;
                  busy_r   <= 1'b0;
               end
            end
            ST_REQ: begin
               if (inta) begin
                  intr_r  <= 1'b0;
                  state_r <= ST_SERVICE;
               end else begin
                  intr_r  <= 1'b1;
               end
            end
            ST_SERVICE: begin
               if (eoi) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               intr_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign intr    = intr_r;
   assign busy    = busy_r;
   assign irq_id  = irq_id_r;
   assign pending = pending_r;
   assign mask    = mask_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
//
// Self-checking bench for irq_ctrl in its default build, without the input
// synchronizer. It has three parts:
//   - hand-written reset, masked-latch, no-retraction and async-reset sequences
//   - a table of single-cycle vectors covering request, priority and
//     ignored-protocol cases
//   - a randomized run compared against a behavioural model
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] irq_src;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       inta;
   logic       eoi;
   logic       intr;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic [7:0] mask;
   logic       busy;

   int total = 0;
   int bad   = 0;

   irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
      .SI_ClkIn   (clk),
      .SI_Reset_N (rst_n),
      .irq_src    (irq_src),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .inta       (inta),
      .eoi        (eoi),
      .intr       (intr),
      .irq_id     (irq_id),
      .pending    (pending),
      .mask       (mask),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] src;
      logic       we;
      logic [7:0] wd;
      logic       ack;
      logic       end_irq;
      logic       e_intr;
      logic [2:0] e_id;
      logic [7:0] e_pend;
      logic [7:0] e_mask;
      logic       e_busy;
   } vec_t;

   vec_t vecs[15];

   // Behavioural model state. st: 0 = waiting, 1 = requesting, 2 = in service.
   int         m_st;
   int         m_id;
   logic [7:0] m_prev;
   logic [7:0] m_pend;
   logic [7:0] m_mask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [7:0] s, input logic w, input logic [7:0] d,
                         input logic a, input logic e);
      irq_src    = s;
      mask_we    = w;
      mask_wdata = d;
      inta       = a;
      eoi        = e;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_in(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_id   = 0;
      m_prev = 8'h00;
      m_pend = 8'h00;
      m_mask = 8'h00;
   endtask

   // Advances the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [7:0] rise;
      logic [7:0] clear;
      logic [7:0] elig;
      rise  = irq_src & ~m_prev;
      clear = 8'h00;
      if (m_st == 1 && inta) clear = 8'h01 << m_id;
      elig = m_pend & m_mask;
      if (m_st == 0) begin
         if (elig != 8'h00) begin
            for (int i = 7; i >= 0; i--) if (elig[i]) m_id = i;
            m_st = 1;
         end
      end else if (m_st == 1) begin
         if (inta) m_st = 2;
      end else begin
         if (eoi) m_st = 0;
      end
      m_pend = (m_pend & ~clear) | rise;
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq_src;
   endtask

   initial begin
      // single request on source 2, mask 8'h04
      vecs[0]  = '{8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h04, 1'b0};
      vecs[1]  = '{8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04, 8'h04, 1'b0};
      vecs[2]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h04, 1'b1};
      vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 8'h04, 1'b1};
      vecs[4]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h04, 1'b1};
      vecs[5]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h04, 1'b1};
      vecs[6]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h04, 1'b0};
      // priority: sources 5 and 1 together, all enabled
      vecs[7]  = '{8'h22, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h22, 8'hFF, 1'b0};
      vecs[8]  = '{8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h22, 8'hFF, 1'b1};
      vecs[9]  = '{8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h20, 8'hFF, 1'b1};
      vecs[10] = '{8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 8'h20, 8'hFF, 1'b0};
      vecs[11] = '{8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 8'hFF, 1'b1};
      vecs[12] = '{8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b1};
      vecs[13] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b0};
      // inta and eoi while idle are both ignored
      vecs[14] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b0};

      // ---- reset with all sources high ----
      rst_n = 1'b0;
      set_in(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      chk("rst_intr", intr, 0);
      chk("rst_id", irq_id, 0);
      chk("rst_pend", pending, 0);
      chk("rst_mask", mask, 0);
      chk("rst_busy", busy, 0);
      tick();
      tick();
      chk("rst_hold_pend", pending, 0);
      rst_n = 1'b1;
      tick();
      chk("rel_pend", pending, 8'hFF);
      chk("rel_intr", intr, 0);
      tick();
      chk("rel_intr2", intr, 0);
      chk("rel_pend2", pending, 8'hFF);

      // ---- table-driven vectors ----
      do_reset();
      for (int i = 0; i < 15; i++) begin
         set_in(vecs[i].src, vecs[i].we, vecs[i].wd, vecs[i].ack, vecs[i].end_irq);
         tick();
         chk($sformatf("v%0d_intr", i), intr, vecs[i].e_intr);
         chk($sformatf("v%0d_id", i), irq_id, vecs[i].e_id);
         chk($sformatf("v%0d_pend", i), pending, vecs[i].e_pend);
         chk($sformatf("v%0d_mask", i), mask, vecs[i].e_mask);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      end

      // ---- masked latch, then enable through a mask write ----
      do_reset();
      set_in(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("ml_pend", pending, 8'h08);
      set_in(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("ml_quiet", intr, 0);
      end
      set_in(8'h00, 1'b1, 8'h08, 1'b0, 1'b0);
      tick();
      chk("ml_w_mask", mask, 8'h08);
      chk("ml_w_intr", intr, 0);
      set_in(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("ml_intr", intr, 1);
      chk("ml_id", irq_id, 3);

      // ---- no retraction, set wins over clear, async reset in service ----
      do_reset();
      set_in(8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
      tick();
      set_in(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("nr_intr", intr, 1);
      chk("nr_id", irq_id, 0);
      set_in(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      chk("nr_mask0", mask, 8'h00);
      chk("nr_hold1", intr, 1);
      set_in(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("nr_hold2", intr, 1);
      set_in(8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("sw_intr", intr, 0);
      chk("sw_pend", pending, 8'h01);
      chk("sw_busy", busy, 1);
      set_in(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("svc_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_intr", intr, 0);
      chk("ar_pend", pending, 0);
      tick();
      rst_n = 1'b1;

      // ---- randomized run against the model ----
      do_reset();
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         irq_src    = irq_src ^ (8'($urandom) & 8'($urandom));
         mask_we    = ($urandom_range(0, 7) == 0);
         mask_wdata = 8'($urandom);
         inta       = 1'($urandom);
         eoi        = ($urandom_range(0, 3) == 0);
         model_step();
         tick();
         chk("rnd_intr", intr, (m_st == 1));
         chk("rnd_busy", busy, (m_st != 0));
         chk("rnd_id", irq_id, m_id);
         chk("rnd_pend", pending, m_pend);
         chk("rnd_mask", mask, m_mask);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
